// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM-stage controller and its MEM/WB register.
package mem_stage_pkg;

    localparam int DW_DEF          = 32;
    localparam int RW_DEF          = 5;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    // Control bits written into MEM/WB while the stage is stalled.
    localparam logic BUBBLE_REGWRITE = 1'b0;
    localparam logic BUBBLE_MEMTOREG = 1'b0;

endpackage

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register: loads the retiring instruction, or a bubble while stalled.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          bubble,
    input  logic          regWriteIn,
    input  logic          memToRegIn,
    input  logic [DW-1:0] readDataIn,
    input  logic [DW-1:0] resultIn,
    input  logic [DW-1:0] pcNewIn,
    input  logic [DW-1:0] instructionIn,
    input  logic [RW-1:0] writeRegIn,
    output logic          regWrite,
    output logic          memToReg,
    output logic [DW-1:0] readData,
    output logic [DW-1:0] result,
    output logic [DW-1:0] pcNew,
    output logic [DW-1:0] instruction,
    output logic [RW-1:0] writeReg
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regWrite    <= 1'b0;
            memToReg    <= 1'b0;
            readData    <= '0;
            result      <= '0;
            pcNew       <= '0;
            instruction <= '0;
            writeReg    <= '0;
        end else if (bubble) begin
            // Only the control bits are killed; data fields keep their last values.
            regWrite <= BUBBLE_REGWRITE;
            memToReg <= BUBBLE_MEMTOREG;
        end else begin
            regWrite    <= regWriteIn;
            memToReg    <= memToRegIn;
            readData    <= readDataIn;
            result      <= resultIn;
            pcNew       <= pcNewIn;
            instruction <= instructionIn;
            writeReg    <= writeRegIn;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: branch resolve, req/ack data-memory access with stall, MEM/WB load.
// Optional access watchdog with sticky err_o is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int RW          = RW_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ex_mem_regwrite_i,
    input  logic          ex_mem_memread_i,
    input  logic          ex_mem_memwrite_i,
    input  logic          ex_mem_memtoreg_i,
    input  logic          ex_mem_branch_i,
    input  logic          ex_mem_zero_i,
    input  logic [DW-1:0] ex_mem_branch_addr_i,
    input  logic [DW-1:0] ex_mem_result_i,
    input  logic [DW-1:0] ex_mem_reg_out2_i,
    input  logic [RW-1:0] ex_mem_writereg_i,
    input  logic [DW-1:0] ex_mem_pc_new_i,
    input  logic [DW-1:0] ex_mem_instruction_i,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [DW-1:0] dmem_addr_o,
    output logic [DW-1:0] dmem_wdata_o,
    input  logic [DW-1:0] dmem_rdata_i,
    input  logic          dmem_ack_i,
    output logic          stall_o,
    output logic          pcsrc_o,
    output logic [DW-1:0] branch_target_o,
    output logic          mem_wb_regwrite_o,
    output logic          mem_wb_memtoreg_o,
    output logic [DW-1:0] mem_wb_read_data_o,
    output logic [DW-1:0] mem_wb_result_o,
    output logic [DW-1:0] mem_wb_pc_new_o,
    output logic [DW-1:0] mem_wb_instruction_o,
    output logic [RW-1:0] mem_wb_writereg_o,
    output logic          err_o
);

    mem_state_e stateQ;
    logic       accessReq;
    logic       isRead;
    logic       ackHit;
    logic       timeoutHit;
    logic       accessDone;
    logic [DW-1:0] readDataNext;

    assign accessReq  = ex_mem_memread_i | ex_mem_memwrite_i;
    assign isRead     = ex_mem_memread_i & ~ex_mem_memwrite_i;
    assign ackHit     = (stateQ == BUSY) & dmem_ack_i;
    assign accessDone = ackHit | timeoutHit;

    // Low in the completion cycle so EX/MEM advances and MEM/WB loads on the same edge.
    assign stall_o = ((stateQ == IDLE) & accessReq) | ((stateQ == BUSY) & ~accessDone);

    assign pcsrc_o         = ex_mem_branch_i & ex_mem_zero_i;
    assign branch_target_o = ex_mem_branch_addr_i;

    assign readDataNext = (ackHit & isRead) ? dmem_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateQ       <= IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (accessReq) begin
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= ex_mem_memwrite_i;
                        dmem_addr_o  <= ex_mem_result_i;
                        dmem_wdata_o <= ex_mem_reg_out2_i;
                        stateQ       <= BUSY;
                    end
                end
                BUSY: begin
                    if (accessDone) begin
                        dmem_req_o <= 1'b0;
                        stateQ     <= IDLE;
                    end
                end
                default: stateQ <= IDLE;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] tmoCnt;
    logic       errQ;

    assign timeoutHit = (stateQ == BUSY) & ~dmem_ack_i & (tmoCnt == TMO_LAST);
    assign err_o      = errQ;

    // Held at zero while idle, so it starts from zero on every entry to BUSY.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmoCnt <= '0;
            errQ   <= 1'b0;
        end else begin
            if (stateQ == IDLE) begin
                tmoCnt <= '0;
            end else if (~dmem_ack_i) begin
                tmoCnt <= tmoCnt + 8'd1;
            end
            if (timeoutHit) begin
                errQ <= 1'b1;
            end
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign err_o      = 1'b0;
`endif

    mem_wb_reg #(
        .DW(DW),
        .RW(RW)
    ) u_mem_wb_reg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bubble       (stall_o),
        .regWriteIn   (ex_mem_regwrite_i),
        .memToRegIn   (ex_mem_memtoreg_i),
        .readDataIn   (readDataNext),
        .resultIn     (ex_mem_result_i),
        .pcNewIn      (ex_mem_pc_new_i),
        .instructionIn(ex_mem_instruction_i),
        .writeRegIn   (ex_mem_writereg_i),
        .regWrite     (mem_wb_regwrite_o),
        .memToReg     (mem_wb_memtoreg_o),
        .readData     (mem_wb_read_data_o),
        .result       (mem_wb_result_o),
        .pcNew        (mem_wb_pc_new_o),
        .instruction  (mem_wb_instruction_o),
        .writeReg     (mem_wb_writereg_o)
    );

endmodule
